// File: rtl/mii_pkg.sv
// Shared MII definitions: transmit state encoding, framing constants and CRC-32 parameters.
package mii_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPreamble,
        StSfd,
        StData,
        StFcs,
        StErr,
        StIfg
    } mii_tx_state_e;

    localparam logic [3:0]  PREAMBLE_NIBBLE = 4'h5;
    localparam logic [3:0]  SFD_HI          = 4'hD;
    localparam logic [31:0] CRC_INIT        = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_POLY_REFL   = 32'hEDB88320;

    // FCS goes out least-significant nibble first.
    function automatic logic [3:0] fcs_nibble(input logic [31:0] fcs, input logic [2:0] idx);
        return fcs[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide update of the reflected Ethernet CRC-32 (LSB of d processed first).
module crc32_d8
    import mii_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  d,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/mii_tx.sv
// MII transmit framer: preamble/SFD insertion, nibble serialisation, CRC-32 FCS and IFG timing.
module mii_tx
    import mii_pkg::*;
#(
    parameter int unsigned PREAMBLE_BYTES = 7,
    parameter int unsigned IFG_BYTES      = 12,
    parameter bit          APPEND_FCS     = 1'b1
) (
    input  logic       mii_clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_d,
    input  logic       tx_last,
    output logic       tx_rdy,
    output logic       busy,
    output logic       mii_tx_en,
    output logic       mii_tx_er,
    output logic [3:0] mii_txd
);

    localparam logic [4:0] PreLast = 5'(2 * PREAMBLE_BYTES - 1);
    localparam logic [5:0] IfgLast = 6'(2 * IFG_BYTES - 1);

    mii_tx_state_e state_q, state_d;
    logic          nib_q, nib_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [5:0]    ifg_q, ifg_d;
    logic [31:0]   crc_q, crc_d, crc_next;
    logic [3:0]    hi_q, hi_d;
    logic          last_q, last_d;
    logic          en_q, en_d, er_q, er_d, rdy_q, rdy_d;
    logic [3:0]    txd_q, txd_d;
    logic          take_byte;

    crc32_d8 u_crc (
        .crc_in  (crc_q),
        .d       (tx_d),
        .crc_out (crc_next)
    );

    always_comb begin
        state_d   = state_q;
        nib_d     = nib_q;
        cnt_d     = cnt_q;
        ifg_d     = ifg_q;
        crc_d     = crc_q;
        hi_d      = hi_q;
        last_d    = last_q;
        en_d      = 1'b0;
        er_d      = 1'b0;
        rdy_d     = 1'b0;
        txd_d     = 4'h0;
        take_byte = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (tx_valid) begin
                    state_d = StPreamble;
                    cnt_d   = '0;
                    crc_d   = CRC_INIT;
                    en_d    = 1'b1;
                    txd_d   = PREAMBLE_NIBBLE;
                end
            end
            StPreamble: begin
                en_d  = 1'b1;
                txd_d = PREAMBLE_NIBBLE;
                if (cnt_q == PreLast) begin
                    state_d = StSfd;
                    nib_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StSfd: begin
                if (!nib_q) begin
                    nib_d = 1'b1;
                    en_d  = 1'b1;
                    txd_d = SFD_HI;
                    rdy_d = 1'b1;
                end else begin
                    take_byte = 1'b1;
                end
            end
            StData: begin
                if (!nib_q) begin
                    nib_d = 1'b1;
                    en_d  = 1'b1;
                    txd_d = hi_q;
                    rdy_d = !last_q;
                end else if (!last_q) begin
                    take_byte = 1'b1;
                end else if (APPEND_FCS) begin
                    state_d = StFcs;
                    cnt_d   = '0;
                    en_d    = 1'b1;
                    txd_d   = fcs_nibble(~crc_q, 3'd0);
                end else begin
                    state_d = StIfg;
                    ifg_d   = '0;
                end
            end
            StFcs: begin
                if (cnt_q == 5'd7) begin
                    state_d = StIfg;
                    ifg_d   = '0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                    en_d  = 1'b1;
                    txd_d = fcs_nibble(~crc_q, cnt_q[2:0] + 3'd1);
                end
            end
            StErr: begin
                if (cnt_q == 5'd1) begin
                    state_d = StIfg;
                    ifg_d   = '0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                    en_d  = 1'b1;
                    er_d  = 1'b1;
                end
            end
            StIfg: begin
                if (ifg_q == IfgLast) begin
                    state_d = StIdle;
                end else begin
                    ifg_d = ifg_q + 6'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // tx_rdy was high this cycle: either a byte is accepted or the source underran.
        if (take_byte) begin
            if (tx_valid) begin
                state_d = StData;
                nib_d   = 1'b0;
                hi_d    = tx_d[7:4];
                last_d  = tx_last;
                crc_d   = crc_next;
                en_d    = 1'b1;
                txd_d   = tx_d[3:0];
            end else begin
                state_d = StErr;
                cnt_d   = '0;
                en_d    = 1'b1;
                er_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge mii_clk) begin
        if (reset) begin
            state_q <= StIdle;
            nib_q   <= 1'b0;
            cnt_q   <= '0;
            ifg_q   <= '0;
            crc_q   <= CRC_INIT;
            hi_q    <= '0;
            last_q  <= 1'b0;
            en_q    <= 1'b0;
            er_q    <= 1'b0;
            rdy_q   <= 1'b0;
            txd_q   <= '0;
        end else begin
            state_q <= state_d;
            nib_q   <= nib_d;
            cnt_q   <= cnt_d;
            ifg_q   <= ifg_d;
            crc_q   <= crc_d;
            hi_q    <= hi_d;
            last_q  <= last_d;
            en_q    <= en_d;
            er_q    <= er_d;
            rdy_q   <= rdy_d;
            txd_q   <= txd_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign tx_rdy    = rdy_q;
    assign mii_tx_en = en_q;
    assign mii_tx_er = er_q;
    assign mii_txd   = txd_q;

endmodule

// File: tb/tb_mii_tx.sv
// Directed bench for mii_tx with a nibble scoreboard on the FCS instance and inline checks on a no-FCS instance.
module tb_mii_tx;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_valid = 1'b0, tx_last = 1'b0;
    logic [7:0] tx_d = 8'h00;
    logic       tx_rdy, busy, mii_tx_en, mii_tx_er;
    logic [3:0] mii_txd;

    logic       tx_valid_nf = 1'b0, tx_last_nf = 1'b0;
    logic [7:0] tx_d_nf = 8'h00;
    logic       tx_rdy_nf, busy_nf, mii_tx_en_nf, mii_tx_er_nf;
    logic [3:0] mii_txd_nf;

    mii_tx dut (
        .mii_clk   (clk),
        .reset     (reset),
        .tx_valid  (tx_valid),
        .tx_d      (tx_d),
        .tx_last   (tx_last),
        .tx_rdy    (tx_rdy),
        .busy      (busy),
        .mii_tx_en (mii_tx_en),
        .mii_tx_er (mii_tx_er),
        .mii_txd   (mii_txd)
    );

    mii_tx #(.APPEND_FCS(1'b0)) dut_nf (
        .mii_clk   (clk),
        .reset     (reset),
        .tx_valid  (tx_valid_nf),
        .tx_d      (tx_d_nf),
        .tx_last   (tx_last_nf),
        .tx_rdy    (tx_rdy_nf),
        .busy      (busy_nf),
        .mii_tx_en (mii_tx_en_nf),
        .mii_tx_er (mii_tx_er_nf),
        .mii_txd   (mii_txd_nf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard entries are {tx_en, tx_er, txd}.
    logic [5:0] exp_q[$];
    logic       mon_on = 1'b0;
    int         en_cycles = 0, rdy_ifg = 0, last_fall = 0, gap_rise = 0, busy_gap = 0;
    logic       prev_en = 1'b0, prev_busy = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (mii_tx_en || mii_tx_er) begin
                    en_cycles++;
                    check("nibble_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) check("mii_nibble", {mii_tx_en, mii_tx_er, mii_txd},
                                                 exp_q.pop_front());
                end
                if (busy && !mii_tx_en && tx_rdy) rdy_ifg++;
                if (prev_en && !mii_tx_en) last_fall = cyc;
                if (!prev_en && mii_tx_en) gap_rise = cyc - last_fall;
                if (prev_busy && !busy) busy_gap = cyc - last_fall;
                prev_en = mii_tx_en;
                prev_busy = busy;
            end
        end
    end

    function automatic logic [31:0] crc_ref(input bq_t b);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            c ^= {24'h0, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    task automatic push_pre();
        for (int i = 0; i < 15; i++) exp_q.push_back({2'b10, 4'h5});
        exp_q.push_back({2'b10, 4'hD});
    endtask

    task automatic push_bytes(input bq_t b);
        foreach (b[i]) begin
            exp_q.push_back({2'b10, b[i][3:0]});
            exp_q.push_back({2'b10, b[i][7:4]});
        end
    endtask

    task automatic push_fcs(input logic [31:0] crc);
        logic [31:0] f = ~crc;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({2'b10, f[3:0]});
            f = f >> 4;
        end
    endtask

    // Offers bytes until nacc have been accepted; drops tx_valid afterwards unless hold is set.
    task automatic send_frame(input bq_t b, input int nacc, input bit hold);
        for (int i = 0; i < nacc; i++) begin
            int g = 0;
            tx_valid = 1'b1;
            tx_d     = b[i];
            tx_last  = (i == b.size() - 1);
            do begin
                @(negedge clk);
                g++;
            end while (!tx_rdy && g < 200);
            check("rdy_seen", tx_rdy, 1);
            @(posedge clk);
            #1;
        end
        if (!hold || nacc < b.size()) tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 2000);
        check("idle_reached", busy, 0);
        @(negedge clk);
    endtask

    bq_t f1, fa, fb, fu, fr, fn;

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_tx_en", mii_tx_en, 0);
        check("rst_tx_er", mii_tx_er, 0);
        check("rst_txd", mii_txd, 0);
        check("rst_tx_rdy", tx_rdy, 0);
        check("rst_busy", busy, 0);
        check("rst_busy_nf", busy_nf, 0);
        mon_on = 1'b1;

        // "123456789" with its well-known FCS nibbles.
        f1 = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        en_cycles = 0;
        push_pre();
        push_bytes(f1);
        exp_q.push_back({2'b10, 4'h6}); exp_q.push_back({2'b10, 4'h2});
        exp_q.push_back({2'b10, 4'h9}); exp_q.push_back({2'b10, 4'h3});
        exp_q.push_back({2'b10, 4'h4}); exp_q.push_back({2'b10, 4'hF});
        exp_q.push_back({2'b10, 4'hB}); exp_q.push_back({2'b10, 4'hC});
        send_frame(f1, 9, 1'b0);
        wait_idle();
        check("f1_drained", exp_q.size(), 0);
        check("f1_en_cycles", en_cycles, 42);
        check("f1_ifg_len", busy_gap, 24);

        // Single byte, no FCS.
        fork
            begin : nf_drive
                int g = 0;
                tx_valid_nf = 1'b1;
                tx_d_nf     = 8'hA5;
                tx_last_nf  = 1'b1;
                do begin
                    @(negedge clk);
                    g++;
                end while (!tx_rdy_nf && g < 100);
                check("nf_rdy", tx_rdy_nf, 1);
                @(posedge clk);
                #1 tx_valid_nf = 1'b0;
            end
            begin : nf_watch
                int g = 0;
                int n = 0;
                logic [3:0] e;
                do begin
                    @(negedge clk);
                    g++;
                end while (!mii_tx_en_nf && g < 100);
                for (int i = 0; i < 18; i++) begin
                    e = (i < 15) ? 4'h5 : (i == 15) ? 4'hD : (i == 16) ? 4'h5 : 4'hA;
                    check("nf_nibble", {mii_tx_en_nf, mii_txd_nf}, {1'b1, e});
                    @(negedge clk);
                end
                check("nf_en_fall", mii_tx_en_nf, 0);
                while (busy_nf && n < 100) begin
                    n++;
                    @(negedge clk);
                end
                check("nf_busy_tail", n, 24);
            end
        join

        // Back-to-back frames, tx_valid never drops between them.
        fa = {8'h00, 8'hFF};
        fb = {8'hDE, 8'hAD, 8'hBE};
        push_pre(); push_bytes(fa); push_fcs(crc_ref(fa));
        push_pre(); push_bytes(fb); push_fcs(crc_ref(fb));
        send_frame(fa, 2, 1'b1);
        send_frame(fb, 3, 1'b0);
        wait_idle();
        check("b2b_drained", exp_q.size(), 0);
        check("b2b_rise_gap", gap_rise, 25);

        // Underrun at the third tx_rdy.
        fu = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        push_pre(); push_bytes({8'h11, 8'h22});
        exp_q.push_back({2'b11, 4'h0});
        exp_q.push_back({2'b11, 4'h0});
        send_frame(fu, 2, 1'b0);
        wait_idle();
        check("urun_drained", exp_q.size(), 0);
        check("urun_ifg_len", busy_gap, 24);

        // Reset while the second data byte is on the wire.
        fr = {8'hA1, 8'hB2, 8'hC3};
        push_pre(); push_bytes({8'hA1});
        exp_q.push_back({2'b10, 4'h2});
        send_frame(fr, 2, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("mid_rst_tx_en", mii_tx_en, 0);
        check("mid_rst_tx_er", mii_tx_er, 0);
        check("mid_rst_txd", mii_txd, 0);
        check("mid_rst_tx_rdy", tx_rdy, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_drained", exp_q.size(), 0);

        fn = {8'h5A, 8'hC3};
        en_cycles = 0;
        push_pre(); push_bytes(fn); push_fcs(crc_ref(fn));
        send_frame(fn, 2, 1'b0);
        wait_idle();
        check("post_rst_drained", exp_q.size(), 0);
        check("post_rst_en_cycles", en_cycles, 28);
        check("rdy_in_ifg", rdy_ifg, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
